// File: rtl/uart_rx_edge_bit_sampler_if.sv
// Bundle between the RX FSM side (master) and the edge/bit sampler (slave).
// It carries the serial line, the control enables and the counter/sample results.
interface uart_rx_edge_bit_sampler_if #(
  parameter int PRESCALE_W = 6
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  cnt_en;
  logic                  dat_samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  sampled_bit;
  logic                  sample_valid;
  logic                  frame_done;

  modport master (
    output rx_in, prescale, par_en, cnt_en, dat_samp_en,
    input  edge_cnt, bit_cnt, sampled_bit, sample_valid, frame_done
  );

  modport slave (
    input  rx_in, prescale, par_en, cnt_en, dat_samp_en,
    output edge_cnt, bit_cnt, sampled_bit, sample_valid, frame_done
  );
endinterface

// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX front end: synchronises the line, counts oversampling edges and frame bits,
// and majority-votes three mid-bit samples into sampled_bit once per bit period.
module uart_rx_edge_bit_sampler #(
  parameter int PRESCALE_W = 6
) (
  input logic                       clk,
  input logic                       rst,
  uart_rx_edge_bit_sampler_if.slave bus
);
  localparam logic [PRESCALE_W-1:0] P_DEF = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] ONE   = PRESCALE_W'(1);

  logic                  rx_meta_q, rx_s_q;
  logic                  cnt_en_q;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [3:0]            bit_q, bit_d;
  logic [2:0]            s_q, s_d;
  logic                  sbit_q, sbit_d;
  logic                  sv_q, sv_d;
  logic                  fd_q, fd_d;

  logic                  rise;
  logic [PRESCALE_W-1:0] p_sel, p_eff, mid;
  logic                  wrap, last_bit, samp_on;

  always_comb begin
    rise = bus.cnt_en & ~cnt_en_q;
    if (bus.prescale == PRESCALE_W'(8) || bus.prescale == PRESCALE_W'(16) ||
        bus.prescale == PRESCALE_W'(32))
      p_sel = bus.prescale;
    else
      p_sel = P_DEF;
    // The ratio is only taken on the rising edge of cnt_en, so mid-frame changes are ignored.
    p_eff    = rise ? p_sel : p_q;
    mid      = p_eff >> 1;
    wrap     = (edge_q == p_eff - ONE);
    last_bit = (bit_q == (bus.par_en ? 4'd10 : 4'd9));
    samp_on  = bus.cnt_en & bus.dat_samp_en;

    p_d    = p_eff;
    edge_d = edge_q;
    bit_d  = bit_q;
    s_d    = s_q;
    sbit_d = sbit_q;
    sv_d   = 1'b0;
    fd_d   = 1'b0;

    if (!bus.cnt_en) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (wrap) begin
      edge_d = '0;
      if (last_bit) begin
        bit_d = '0;
        fd_d  = 1'b1;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else begin
      edge_d = edge_q + ONE;
    end

    if (samp_on) begin
      if (edge_q == mid - ONE) s_d[0] = rx_s_q;
      if (edge_q == mid)       s_d[1] = rx_s_q;
      if (edge_q == mid + ONE) s_d[2] = rx_s_q;
      // Vote one edge after the last capture; bit_cnt cannot change here since mid+2 <= P-1.
      if (edge_q == mid + PRESCALE_W'(2)) begin
        sbit_d = (s_q[0] & s_q[1]) | (s_q[0] & s_q[2]) | (s_q[1] & s_q[2]);
        sv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_en_q  <= 1'b0;
      p_q       <= P_DEF;
      edge_q    <= '0;
      bit_q     <= '0;
      s_q       <= 3'b111;
      sbit_q    <= 1'b1;
      sv_q      <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx_in;
      rx_s_q    <= rx_meta_q;
      cnt_en_q  <= bus.cnt_en;
      p_q       <= p_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      s_q       <= s_d;
      sbit_q    <= sbit_d;
      sv_q      <= sv_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.edge_cnt     = edge_q;
  assign bus.bit_cnt      = bit_q;
  assign bus.sampled_bit  = sbit_q;
  assign bus.sample_valid = sv_q;
  assign bus.frame_done   = fd_q;
endmodule
